// File: rtl/four_bit_down_counter.sv
// Loadable down counter with prescaled stepping, one-shot or auto-reload operation,
// and a one-cycle terminal-count pulse when the count reaches zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | count held, En ignored, waiting for Start or Load
// RUN   | prescaler advances on En, Q steps down, Tc pulses at zero
module four_bit_down_counter #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE   = 1,
    parameter int RST_RELOAD = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] nxt;
    logic             presc_tc;

    // Leaving zero only happens through a reload, never by wrapping the decrement.
    assign nxt      = (Q == '0) ? reload : (Q - 1'b1);
    assign presc_tc = (presc == PS_LAST);
    assign Busy     = (state == RUN);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            presc  <= '0;
            reload <= WIDTH'(RST_RELOAD);
            Q      <= '0;
            Tc     <= 1'b0;
        end else begin
            Tc <= 1'b0;
            if (Load) begin
                Q      <= LoadVal;
                reload <= LoadVal;
                presc  <= '0;
            end else if (Stop) begin
                state <= IDLE;
                presc <= '0;
            end else if (Start && (state == IDLE)) begin
                Q     <= reload;
                presc <= '0;
                state <= RUN;
            end else if ((state == RUN) && En) begin
                if (presc_tc) begin
                    presc <= '0;
                    Q     <= nxt;
                    if (nxt == '0) begin
                        Tc <= 1'b1;
                        if (!Mode) begin
                            state <= IDLE;
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_four_bit_down_counter.sv
// Bench for four_bit_down_counter: two instances (PRESCALE 1 and 4) share stimulus and
// are compared every cycle against an integer model, plus directed literal checks.
module tb_four_bit_down_counter;

    logic       clk;
    logic       rst;
    logic       en, ld, st, sp, md;
    logic [3:0] lv;
    logic [3:0] q1, q4;
    logic       tc1, tc4, busy1, busy4;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 0;

    four_bit_down_counter #(.WIDTH(4), .PRESCALE(1), .RST_RELOAD(15)) dut1 (
        .Clk(clk), .Reset(rst), .En(en), .Load(ld), .LoadVal(lv), .Start(st),
        .Stop(sp), .Mode(md), .Q(q1), .Tc(tc1), .Busy(busy1)
    );

    four_bit_down_counter #(.WIDTH(4), .PRESCALE(4), .RST_RELOAD(15)) dut4 (
        .Clk(clk), .Reset(rst), .En(en), .Load(ld), .LoadVal(lv), .Start(st),
        .Stop(sp), .Mode(md), .Q(q4), .Tc(tc4), .Busy(busy4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: index 0 is PRESCALE=1, index 1 is PRESCALE=4.
    int mq[2], mrel[2], mcnt[2];
    bit mrun[2], mtc[2];
    int pre[2] = '{1, 4};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i] = 0; mrel[i] = 15; mcnt[i] = 0; mrun[i] = 0; mtc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mtc[i] = 0;
                if (ld) begin
                    mq[i] = lv; mrel[i] = lv; mcnt[i] = 0;
                end else if (sp) begin
                    mrun[i] = 0; mcnt[i] = 0;
                end else if (st && !mrun[i]) begin
                    mq[i] = mrel[i]; mcnt[i] = 0; mrun[i] = 1;
                end else if (mrun[i] && en) begin
                    mcnt[i] = mcnt[i] + 1;
                    if (mcnt[i] == pre[i]) begin
                        mcnt[i] = 0;
                        mq[i] = (mq[i] == 0) ? mrel[i] : mq[i] - 1;
                        if (mq[i] == 0) begin
                            mtc[i] = 1;
                            if (!md) mrun[i] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && rst) begin
            chk("m1_q", q1, mq[0]);
            chk("m1_tc", tc1, mtc[0]);
            chk("m1_busy", busy1, mrun[0]);
            chk("m4_q", q4, mq[1]);
            chk("m4_tc", tc4, mtc[1]);
            chk("m4_busy", busy4, mrun[1]);
        end
    end

    task automatic cyc(input bit l, input bit s, input bit p, input bit e, input bit m,
                       input int v);
        ld = l; st = s; sp = p; en = e; md = m; lv = 4'(v);
        @(negedge clk);
    endtask

    initial begin
        rst = 0; en = 0; ld = 0; st = 0; sp = 0; md = 0; lv = 0;
        repeat (2) @(negedge clk);
        chk("rst_q", q1, 0);
        chk("rst_busy", busy1, 0);
        rst = 1;
        cmp_on = 1;
        @(negedge clk);

        // One-shot 3,2,1,0
        cyc(1, 0, 0, 1, 0, 3);  chk("t2_load_q", q1, 3);
        cyc(0, 1, 0, 1, 0, 0);  chk("t2_start_q", q1, 3); chk("t2_start_busy", busy1, 1);
        cyc(0, 0, 0, 1, 0, 0);  chk("t2_q2", q1, 2);
        cyc(0, 0, 0, 1, 0, 0);  chk("t2_q1", q1, 1); chk("t2_tc_early", tc1, 0);
        cyc(0, 0, 0, 1, 0, 0);  chk("t2_q0", q1, 0); chk("t2_tc", tc1, 1); chk("t2_busy_drop", busy1, 0);
        cyc(0, 0, 0, 1, 0, 0);  chk("t2_hold", q1, 0); chk("t2_tc_end", tc1, 0);

        // Auto-reload 2,1,0,2,1,0
        cyc(1, 0, 0, 0, 1, 2);
        cyc(0, 1, 0, 0, 1, 0);  chk("t3_start_q", q1, 2);
        cyc(0, 0, 0, 1, 1, 0);  chk("t3_a1", q1, 1);
        cyc(0, 0, 0, 1, 1, 0);  chk("t3_a0", q1, 0); chk("t3_tc_a", tc1, 1);
        cyc(0, 0, 0, 1, 1, 0);  chk("t3_b2", q1, 2); chk("t3_tc_off", tc1, 0);
        cyc(0, 0, 0, 1, 1, 0);  chk("t3_b1", q1, 1);
        cyc(0, 0, 0, 1, 1, 0);  chk("t3_b0", q1, 0); chk("t3_tc_b", tc1, 1); chk("t3_busy", busy1, 1);
        cyc(0, 0, 1, 0, 1, 0);

        // PRESCALE=4 with En toggling: Tc after the 4th En-high cycle
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);  chk("t4_start_q", q4, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);  chk("t4_q_pre", q4, 1); chk("t4_tc_pre", tc4, 0);
        cyc(0, 0, 0, 0, 0, 0);  chk("t4_q_frozen", q4, 1);
        cyc(0, 0, 0, 1, 0, 0);  chk("t4_q", q4, 0); chk("t4_tc", tc4, 1); chk("t4_busy", busy4, 0);

        // Simultaneous events
        cyc(1, 0, 0, 0, 1, 5);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 1, 7);  chk("t5_ldstop_q", q1, 7); chk("t5_ldstop_busy", busy1, 1);
        cyc(0, 1, 1, 0, 1, 0);  chk("t5_stopstart", busy1, 0);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 0);  chk("t5_run_q", q1, 1);
        cyc(1, 0, 0, 1, 1, 9);  chk("t5_ldstep_q", q1, 9); chk("t5_ldstep_tc", tc1, 0);
        cyc(0, 0, 1, 0, 1, 0);

        // reload=0 one-shot, start while running
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);  chk("t6_zero_busy", busy1, 1);
        cyc(0, 0, 0, 1, 0, 0);  chk("t6_zero_tc", tc1, 1); chk("t6_zero_q", q1, 0); chk("t6_zero_idle", busy1, 0);
        cyc(1, 0, 0, 0, 1, 4);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);  chk("t6_rerun_q", q1, 4); chk("t6_rerun_busy", busy1, 1);

        // Asynchronous reset mid-run with Q=5
        cyc(1, 0, 0, 0, 1, 5);
        cyc(0, 1, 0, 0, 1, 0);  chk("t1_pre_q", q1, 5);
        ld = 0; st = 0;
        #2 rst = 0;
        #1;
        chk("t1_q", q1, 0); chk("t1_tc", tc1, 0); chk("t1_busy", busy1, 0);
        @(negedge clk);
        rst = 1;
        cyc(0, 1, 0, 0, 0, 0);  chk("t1_reload15", q1, 15);
        cyc(0, 0, 1, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                ld = 0; st = 0; sp = 0; en = 0;
                #2 rst = 0;
                @(negedge clk);
                rst = 1;
            end else begin
                cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 75,
                    ($urandom_range(0, 99) < 50) ? md : ~md, $urandom_range(0, 15));
            end
        end

        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
